rr_arb_8: RTL
=============

RR_ARB_8 -- requirements
Module: rr_arb_8

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 15: max consecutive grant cycles per requester before forced release (timeout build only).
REQ-002 SHALL have parameter CNT_W, default 4: hold counter width; HOLD_MAX SHALL fit in CNT_W bits.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req, input, 8: per-requester request level; bit i = requester i.
REQ-006 SHALL have port grant, output, 8: one-hot grant, all-zero when nothing is granted.
REQ-007 SHALL have port grant_idx, output, 3: binary index of granted requester; 0 when grant_vld=0.
REQ-008 SHALL have port grant_vld, output, 1: high exactly when grant is non-zero.
REQ-009 SHALL have port timeout, output, 1: one-cycle pulse when a grant is force-released.

Function
REQ-010 SHALL implement FSM states IDLE and BUSY, all outputs registered.
REQ-011 IDLE: if req!=0 at a rising edge, SHALL move to BUSY at that edge with grant_idx = first set req bit searching ptr, ptr+1, ..., ptr+7 (mod 8).
REQ-012 Grant latency SHALL be exactly 1 cycle from the sampling edge; req=0 in IDLE SHALL keep IDLE, outputs zero.
REQ-013 grant SHALL equal the 3-to-8 one-hot decode of grant_idx whenever grant_vld=1.
REQ-014 BUSY: grant SHALL hold unchanged while req[grant_idx]=1, regardless of other req bits.
REQ-015 BUSY: when req[grant_idx]=0 at an edge, SHALL return to IDLE, clear grant/grant_vld, set ptr = grant_idx+1 (wrap 7->0).
REQ-016 After every release SHALL spend exactly one IDLE cycle with grant=0 before the next grant (no back-to-back grants).
REQ-017 Simultaneous requests SHALL resolve purely by rotation from ptr; requester granted last SHALL have lowest priority next round.
REQ-018 Requester dropping req in IDLE before sampling SHALL not be granted; no request memory.
REQ-019 Hold counter SHALL clear on entry to BUSY and increment each BUSY cycle, saturating at HOLD_MAX.

Reset
REQ-020 rst_n low SHALL immediately force IDLE, grant=0, grant_idx=0, grant_vld=0, timeout=0, ptr=0, counter=0, mid-grant included.
REQ-021 First arbitration after reset deassertion SHALL start search at requester 0.

Configuration
REQ-022 Macro RR_ARB_8_TIMEOUT_EN defined: if grant held HOLD_MAX cycles with req still high, SHALL release as in REQ-015 and pulse timeout for 1 cycle on the release edge.
REQ-023 Macro undefined: no counter, timeout tied 0, grant held until req drops; HOLD_MAX/CNT_W unused.

Structure
REQ-024 Package rr_arb_pkg SHALL hold N_REQ=8, IDX_W=3 and the FSM state typedef (IDLE, BUSY).
REQ-025 One sub-module dec_3to8 SHALL perform the combinational index-to-one-hot decode feeding the grant register.

Verification
REQ-026 Reset then req=8'h00 for 10 cycles -> grant=0, grant_vld=0 throughout.
REQ-027 req=8'h81 from reset, each grantee drops req 3 cycles after grant -> grant 8'h01, idle cycle, 8'h80, idle cycle, 8'h01.
REQ-028 req=8'hFF held, each grantee drops for 1 cycle after 2 grant cycles -> grant_idx sequence 0,1,2,...,7,0.
REQ-029 Timeout build, HOLD_MAX=15, req=8'h04 held 40 cycles -> grant 8'h04 released after 15 cycles, timeout pulses once, regranted after 1 idle cycle.
REQ-030 rst_n asserted mid-grant (grant=8'h20) -> outputs zero same cycle; after release with req=8'h21 -> grant 8'h01 first.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and round-robin search helper for rr_arb_8.
package rr_arb_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // First set request bit scanning ptr, ptr+1, ... ptr+7 (mod 8).
   // The 3-bit add wraps naturally, so no explicit modulo is needed.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] idx;
      logic             found;
      rr_pick = '0;
      found   = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = ptr + IDX_W'(k);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/rr_arb_8_dec.sv
// Combinational 3-to-8 one-hot decoder feeding the grant register.
module dec_3to8
   import rr_arb_pkg::*;
(
   input  logic [IDX_W-1:0] i_idx,
   output logic [N_REQ-1:0] o_onehot
);

   // Single bit set at position i_idx.
   always_comb begin
      o_onehot        = '0;
      o_onehot[i_idx] = 1'b1;
   end

endmodule

// File: rtl/rr_arb_8.sv
// 8-requester round-robin arbiter with registered one-hot grant.
// Optional forced-release timeout enabled by defining RR_ARB_8_TIMEOUT_EN.
// A grant is held while the grantee keeps its request high; every release
// is followed by exactly one idle cycle before the next arbitration.
module rr_arb_8
   import rr_arb_pkg::*;
#(
   parameter int HOLD_MAX = 15,
   parameter int CNT_W    = 4
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_vld,
   output logic             timeout
);

   // Hold limit must be representable in the counter.
   if (HOLD_MAX < 1 || HOLD_MAX >= (1 << CNT_W)) begin : g_bad_cfg
      $error("rr_arb_8: HOLD_MAX does not fit in CNT_W bits");
   end

   state_t           r_state;
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] r_idx;
   logic [N_REQ-1:0] r_grant;
   logic             r_vld;
   logic             r_to;

   state_t           w_nxt_state;
   logic [IDX_W-1:0] w_nxt_ptr;
   logic [IDX_W-1:0] w_nxt_idx;
   logic             w_nxt_vld;
   logic             w_nxt_to;
   logic [N_REQ-1:0] w_dec;
   logic             w_rel;

`ifdef RR_ARB_8_TIMEOUT_EN
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_nxt_cnt;
   logic             w_expire;

   // Grant has been visible HOLD_MAX cycles once the counter reaches HOLD_MAX-1.
   assign w_expire = (r_cnt == CNT_W'(HOLD_MAX - 1));
`else
   logic             w_expire;

   assign w_expire = 1'b0;
`endif

   // Grantee dropped its request.
   assign w_rel = !req[r_idx];

   dec_3to8 u_dec (
      .i_idx    (w_nxt_idx),
      .o_onehot (w_dec)
   );

   // Next-state and next-output logic.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_ptr   = r_ptr;
      w_nxt_idx   = r_idx;
      w_nxt_vld   = r_vld;
      w_nxt_to    = 1'b0;
`ifdef RR_ARB_8_TIMEOUT_EN
      w_nxt_cnt   = r_cnt;
`endif
      case (r_state)
         IDLE: begin
            w_nxt_idx = '0;
            w_nxt_vld = 1'b0;
            if (|req) begin
               w_nxt_state = BUSY;
               w_nxt_idx   = rr_pick(req, r_ptr);
               w_nxt_vld   = 1'b1;
`ifdef RR_ARB_8_TIMEOUT_EN
               w_nxt_cnt   = '0;
`endif
            end
         end
         BUSY: begin
            if (w_rel || w_expire) begin
               // Release: last grantee becomes lowest priority.
               w_nxt_state = IDLE;
               w_nxt_ptr   = r_idx + IDX_W'(1);
               w_nxt_idx   = '0;
               w_nxt_vld   = 1'b0;
               w_nxt_to    = !w_rel && w_expire;
            end
`ifdef RR_ARB_8_TIMEOUT_EN
            else if (r_cnt != CNT_W'(HOLD_MAX)) begin
               w_nxt_cnt = r_cnt + CNT_W'(1);
            end
`endif
         end
         default: begin
            w_nxt_state = IDLE;
            w_nxt_idx   = '0;
            w_nxt_vld   = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_idx   <= '0;
         r_grant <= '0;
         r_vld   <= 1'b0;
         r_to    <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_ptr   <= w_nxt_ptr;
         r_idx   <= w_nxt_idx;
         r_grant <= w_nxt_vld ? w_dec : '0;
         r_vld   <= w_nxt_vld;
         r_to    <= w_nxt_to;
      end
   end

`ifdef RR_ARB_8_TIMEOUT_EN
   // Hold counter: cleared on BUSY entry, saturating increment while held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else        r_cnt <= w_nxt_cnt;
   end
`endif

   assign grant     = r_grant;
   assign grant_idx = r_idx;
   assign grant_vld = r_vld;
   assign timeout   = r_to;

endmodule
